// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared memory port: instruction fetch (IF) and data (DM).
// Registers the winner's address/data/we, holds mem_en for LATENCY cycles, then pulses done.
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              addr_sel,
  output logic              if_gnt,
  output logic              dm_gnt,
  output logic              if_done,
  output logic              dm_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Request/done handshake: a requester raises req and holds it (with stable
  // address/data until granted); the arbiter samples req in IDLE, and the
  // matching one-cycle done pulse marks completion, after which req may drop.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic       OWNER_IF = 1'b0;
  localparam logic       OWNER_DM = 1'b1;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              sel_q, sel_d;
  logic              if_gnt_q, if_gnt_d;
  logic              dm_gnt_q, dm_gnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_dm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= OWNER_IF;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= 1'b0;
      if_gnt_q <= 1'b0;
      dm_gnt_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      if_gnt_q <= if_gnt_d;
      dm_gnt_q <= dm_gnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // On a tie the requester that did not own the port last wins.
  assign grant_dm = dm_req && (!if_req || (last_q == OWNER_IF));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    sel_d    = sel_q;
    if_gnt_d = if_gnt_q;
    dm_gnt_d = dm_gnt_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_INIT;
          if (grant_dm) begin
            addr_d   = dm_addr;
            wdata_d  = dm_wdata;
            we_d     = dm_we;
            sel_d    = 1'b1;
            dm_gnt_d = 1'b1;
            last_d   = OWNER_DM;
          end else begin
            addr_d   = if_addr;
            wdata_d  = '0;
            we_d     = 1'b0;
            sel_d    = 1'b0;
            if_gnt_d = 1'b1;
            last_d   = OWNER_IF;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if_gnt_d = 1'b0;
        dm_gnt_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign addr_sel  = sel_q;
  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_done   = (state_q == S_DONE) & ~sel_q;
  assign dm_done   = (state_q == S_DONE) & sel_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one LATENCY=2 instance for most steps,
// a LATENCY=1 instance for the short-latency fetch.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic        if_req1 = 1'b0, dm_req1 = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;

  logic        mem_en, mem_we, addr_sel, if_gnt, dm_gnt, if_done, dm_done, busy;
  logic [15:0] mem_addr, mem_wdata, rdata;
  logic [1:0]  state_dbg;

  logic        mem_en1, mem_we1, addr_sel1, if_gnt1, dm_gnt1, if_done1, dm_done1, busy1;
  logic [15:0] mem_addr1, mem_wdata1, rdata1;
  logic [1:0]  state_dbg1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(16), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .addr_sel(addr_sel), .if_gnt(if_gnt), .dm_gnt(dm_gnt),
    .if_done(if_done), .dm_done(dm_done), .rdata(rdata), .busy(busy),
    .state_dbg(state_dbg)
  );

  mem_port_arbiter #(.DATA_W(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr),
    .dm_req(dm_req1), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .addr_sel(addr_sel1), .if_gnt(if_gnt1), .dm_gnt(dm_gnt1),
    .if_done(if_done1), .dm_done(dm_done1), .rdata(rdata1), .busy(busy1),
    .state_dbg(state_dbg1)
  );

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_mem_en", 16'(mem_en), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_gnts", {14'h0, if_gnt, dm_gnt}, 16'h0);
    chk("rst_done_busy", {13'h0, if_done, dm_done, busy}, 16'h0);
    chk("rst_state", 16'(state_dbg), 16'h0);
    reset = 1'b0;

    // Single fetch, LATENCY=2
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'hBEEF;
    step();
    chk("f1_if_gnt", 16'(if_gnt), 16'h1);
    chk("f1_mem_en_c1", 16'(mem_en), 16'h1);
    chk("f1_mem_addr", mem_addr, 16'h0010);
    chk("f1_mem_we", 16'(mem_we), 16'h0);
    chk("f1_addr_sel", 16'(addr_sel), 16'h0);
    step();
    chk("f1_mem_en_c2", 16'(mem_en), 16'h1);
    chk("f1_if_done_early", 16'(if_done), 16'h0);
    step();
    chk("f1_mem_en_c3", 16'(mem_en), 16'h0);
    chk("f1_if_done", 16'(if_done), 16'h1);
    chk("f1_rdata", rdata, 16'hBEEF);
    chk("f1_state_done", 16'(state_dbg), 16'h2);
    if_req = 1'b0;
    step();
    chk("f1_if_done_pulse", 16'(if_done), 16'h0);
    chk("f1_idle_gnt", 16'(if_gnt), 16'h0);
    chk("f1_idle_busy", 16'(busy), 16'h0);

    // Simultaneous requests right after reset: DM first, then IF
    do_reset();
    if_req = 1'b1; if_addr = 16'h0040; mem_rdata = 16'h5555;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    step();
    chk("tie_dm_gnt", {14'h0, if_gnt, dm_gnt}, 16'h1);
    chk("tie_addr_sel", 16'(addr_sel), 16'h1);
    chk("tie_mem_we", 16'(mem_we), 16'h1);
    chk("tie_mem_addr", mem_addr, 16'h0200);
    chk("tie_mem_wdata", mem_wdata, 16'h1234);
    step();
    step();
    chk("tie_dm_done", {14'h0, if_done, dm_done}, 16'h1);
    chk("tie_rdata_write", rdata, 16'h0000);
    dm_req = 1'b0;
    step();
    chk("tie_idle_busy", 16'(busy), 16'h0);
    step();
    chk("tie_if_gnt", {14'h0, if_gnt, dm_gnt}, 16'h2);
    chk("tie_if_addr", mem_addr, 16'h0040);
    chk("tie_if_wdata", mem_wdata, 16'h0000);
    chk("tie_if_we", 16'(mem_we), 16'h0);
    step();
    step();
    chk("tie_if_done", {14'h0, if_done, dm_done}, 16'h2);
    chk("tie_if_rdata", rdata, 16'h5555);
    if_req = 1'b0;
    step();

    // Both held for six accesses: strict alternation, one idle cycle between
    dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mem_rdata = 16'hA000 + 16'(k);
      step();
      chk($sformatf("rr%0d_gnt", k), {14'h0, if_gnt, dm_gnt}, (k % 2 == 0) ? 16'h1 : 16'h2);
      chk($sformatf("rr%0d_addr", k), mem_addr, (k % 2 == 0) ? 16'h0200 : 16'h0040);
      chk($sformatf("rr%0d_busy", k), 16'(busy), 16'h1);
      step();
      step();
      chk($sformatf("rr%0d_done", k), {14'h0, if_done, dm_done}, (k % 2 == 0) ? 16'h1 : 16'h2);
      chk($sformatf("rr%0d_rdata", k), rdata, 16'hA000 + 16'(k));
      step();
      chk($sformatf("rr%0d_idle", k), 16'(busy), 16'h0);
      if (k == 5) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end

    // DM write whose request and address change mid-access
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    step();
    chk("chg_dm_gnt", 16'(dm_gnt), 16'h1);
    dm_addr = 16'hFFFF; dm_req = 1'b0; dm_wdata = 16'h0000;
    step();
    chk("chg_mem_en", 16'(mem_en), 16'h1);
    chk("chg_mem_addr", mem_addr, 16'h0200);
    chk("chg_mem_wdata", mem_wdata, 16'h1234);
    step();
    chk("chg_dm_done", 16'(dm_done), 16'h1);
    chk("chg_mem_en_off", 16'(mem_en), 16'h0);
    chk("chg_rdata_kept", rdata, 16'hA005);
    step();
    chk("chg_idle", 16'(busy), 16'h0);

    // Reset on the second ACCESS cycle
    dm_we = 1'b0;
    if_req = 1'b1; if_addr = 16'h0080; mem_rdata = 16'h7777;
    step();
    step();
    chk("ar_mid_mem_en", 16'(mem_en), 16'h1);
    reset = 1'b1;
    #1;
    chk("ar_mem_en", 16'(mem_en), 16'h0);
    chk("ar_mem_addr", mem_addr, 16'h0);
    chk("ar_rdata", rdata, 16'h0);
    chk("ar_gnt_busy", {13'h0, if_gnt, dm_gnt, busy}, 16'h0);
    chk("ar_done", {14'h0, if_done, dm_done}, 16'h0);
    step();
    chk("ar_no_done", {14'h0, if_done, dm_done}, 16'h0);
    reset = 1'b0;
    step();
    chk("ar_regrant", 16'(if_gnt), 16'h1);
    chk("ar_regrant_addr", mem_addr, 16'h0080);
    step();
    step();
    chk("ar_if_done", 16'(if_done), 16'h1);
    chk("ar_if_rdata", rdata, 16'h7777);
    if_req = 1'b0;
    step();

    // LATENCY=1 fetch
    if_req1 = 1'b1; mem_rdata = 16'h1111;
    step();
    chk("l1_if_gnt", 16'(if_gnt1), 16'h1);
    chk("l1_mem_en", 16'(mem_en1), 16'h1);
    chk("l1_mem_addr", mem_addr1, 16'h0080);
    step();
    chk("l1_mem_en_off", 16'(mem_en1), 16'h0);
    chk("l1_if_done", 16'(if_done1), 16'h1);
    chk("l1_rdata", rdata1, 16'h1111);
    if_req1 = 1'b0;
    step();
    chk("l1_idle", {14'h0, if_done1, busy1}, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single 16-bit memory port between two requesters: instruction fetch (IF) and data memory access (DM).
- Registers the winning requester's address, write data and write enable, and drives the port's address-select mux.
- Runs each access for a fixed number of cycles, then returns read data with a one-cycle done pulse.
- Sits between the fetch/load-store control and the unified memory.

Parameters:
- DATA_W, 16, width of the data and address buses.
- LATENCY, 2, number of cycles mem_en is held per access; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch requests a read; held high until if_done.
- if_addr  input  DATA_W  fetch address.
- dm_req  input  1  data requests an access; held high until dm_done.
- dm_we  input  1  1 = write, 0 = read; valid while dm_req is high.
- dm_addr  input  DATA_W  data address.
- dm_wdata  input  DATA_W  data write value.
- mem_rdata  input  DATA_W  memory read data; valid on the last mem_en cycle.
- mem_en  output  1  memory port enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  DATA_W  registered access address.
- mem_wdata  output  DATA_W  registered write data.
- addr_sel  output  1  port mux select: 0 = IF, 1 = DM.
- if_gnt  output  1  fetch owns the port, IDLE exit through DONE.
- dm_gnt  output  1  data owns the port, IDLE exit through DONE.
- if_done  output  1  one-cycle pulse; rdata valid for fetch.
- dm_done  output  1  one-cycle pulse; DM access complete.
- rdata  output  DATA_W  registered read data; holds until the next capture.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: state = IDLE, last_owner = IF, cnt = 0. All outputs are 0, including mem_addr, mem_wdata and rdata.
- Reset is asynchronous and takes effect immediately mid-access. There is no partial done pulse and no pending grant afterwards.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant that requester.
  - Both requesting: grant the requester that is not last_owner (round-robin). After reset, a tie goes to DM.
  - On grant: capture addr, wdata and we into registers (IF: we = 0, wdata = 0). Set addr_sel and the grant flag, set last_owner, set cnt = LATENCY-1, go to ACCESS.
- ACCESS:
  - mem_en = 1, and mem_we = the registered we, for exactly LATENCY cycles.
  - Each cycle: if cnt == 0, capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to DONE. Otherwise decrement cnt.
- DONE:
  - Pulse the owner's done for one cycle. mem_en = 0. Clear the grants. Return to IDLE.
  - Arbitration resumes in the next IDLE cycle. Minimum spacing between grants is therefore LATENCY+2 cycles.
- Latency: request sampled in IDLE at edge N → done high in cycle N+LATENCY+1.
- Request changes while granted:
  - A request that drops while granted is ignored; the access still completes and done still pulses.
  - Address and data changes after the grant are ignored because the values were captured at grant.
- The losing requester waits with its req held. It is guaranteed service at the next arbitration, so there is no starvation.
- mem_addr and mem_wdata hold their last values when idle; mem_en = 0 makes them don't-care at the memory.
- The grant flags and addr_sel are mutually exclusive by construction: if_gnt and dm_gnt are never both 1.

Test Plan:
- Reset then if_req = 1, if_addr = 0x0010, mem_rdata = 0xBEEF, LATENCY = 2 → if_gnt rises the next cycle. mem_en is high for exactly 2 cycles with mem_addr = 0x0010 and mem_we = 0. if_done pulses in cycle 3 with rdata = 0xBEEF.
- After reset, if_req and dm_req rise together (dm_we = 1, dm_addr = 0x0200, dm_wdata = 0x1234) → DM is granted first with mem_we = 1, mem_wdata = 0x1234, and dm_done pulses. IF is granted in the following IDLE cycle and if_done follows 3 cycles later.
- Both requests held continuously for 6 accesses → grants alternate DM, IF, DM, IF, DM, IF, and busy is low for exactly one cycle between accesses.
- DM write granted, then dm_addr changes to 0xFFFF and dm_req drops mid-ACCESS → mem_addr stays 0x0200, the access runs LATENCY cycles, dm_done still pulses, and rdata is unchanged.
- reset asserted on the second ACCESS cycle → all outputs are 0 immediately and no done pulse occurs. After release with if_req held, a fresh IF access completes normally.
- LATENCY = 1: single fetch → mem_en is high for 1 cycle and if_done arrives 2 cycles after the request is sampled.
